// File: rtl/ascon_perm_ctrl_if.sv
// Handshake and control bundle between the ASCON mode FSM (master) and the
// permutation sequencer (slave); the slave's outputs feed the datapath controls.
interface ascon_perm_ctrl_if;
   logic       start_i;
   logic       mode_i;
   logic       load_i;
   logic       xor_data_i;
   logic       xor_key_begin_i;
   logic       xor_key_end_i;
   logic       xor_lsb_i;
   logic [3:0] counter_o;
   logic       data_sel_o;
   logic       en_reg_state_o;
   logic       en_xor_data_o;
   logic       en_xor_key_o;
   logic       en_xor_key_end_o;
   logic       en_xor_lsb_o;
   logic       busy_o;
   logic       done_o;

   modport master (
      output start_i, mode_i, load_i, xor_data_i, xor_key_begin_i,
             xor_key_end_i, xor_lsb_i,
      input  counter_o, data_sel_o, en_reg_state_o, en_xor_data_o,
             en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o, busy_o, done_o
   );

   modport slave (
      input  start_i, mode_i, load_i, xor_data_i, xor_key_begin_i,
             xor_key_end_i, xor_lsb_i,
      output counter_o, data_sel_o, en_reg_state_o, en_xor_data_o,
             en_xor_key_o, en_xor_key_end_o, en_xor_lsb_o, busy_o, done_o
   );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Sequences one ASCON permutation (p^a: rounds 0..11, p^b: rounds 6..11) on the
// permutation datapath; all outputs are Moore-decoded from registered state.
module ascon_perm_ctrl (
   input  logic              clock_i,
   input  logic              resetb_i,
   ascon_perm_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIRST = 2'd1;
   localparam logic [1:0] ST_ROUND = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] RND_PA   = 4'd0;
   localparam logic [3:0] RND_PB   = 4'd6;
   localparam logic [3:0] RND_LAST = 4'd11;

   logic [1:0] state, state_nxt;
   logic [3:0] rnd, rnd_nxt;
   logic       cfg_latch;

   logic       f_load;
   logic       f_xor_data;
   logic       f_xor_key_begin;
   logic       f_xor_key_end;
   logic       f_xor_lsb;

   logic       in_first, in_round, in_busy, last_round;

   assign in_first   = (state == ST_FIRST);
   assign in_round   = (state == ST_ROUND);
   assign in_busy    = in_first | in_round;
   // Values above 11 cannot occur normally; if forced, they end the permutation.
   assign last_round = (rnd >= RND_LAST);

   always_comb begin
      state_nxt = state;
      rnd_nxt   = rnd;
      cfg_latch = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start_i) begin
               state_nxt = ST_FIRST;
               rnd_nxt   = bus.mode_i ? RND_PB : RND_PA;
               cfg_latch = 1'b1;
            end
         end
         ST_FIRST, ST_ROUND: begin
            if (last_round) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_ROUND;
               rnd_nxt   = rnd + 4'd1;
            end
         end
         ST_DONE: begin
            if (bus.start_i) begin
               state_nxt = ST_FIRST;
               rnd_nxt   = bus.mode_i ? RND_PB : RND_PA;
               cfg_latch = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
               rnd_nxt   = RND_PA;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            rnd_nxt   = RND_PA;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state <= ST_IDLE;
         rnd   <= RND_PA;
      end else begin
         state <= state_nxt;
         rnd   <= rnd_nxt;
      end
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         f_load          <= 1'b0;
         f_xor_data      <= 1'b0;
         f_xor_key_begin <= 1'b0;
         f_xor_key_end   <= 1'b0;
         f_xor_lsb       <= 1'b0;
      end else if (cfg_latch) begin
         f_load          <= bus.load_i;
         f_xor_data      <= bus.xor_data_i;
         f_xor_key_begin <= bus.xor_key_begin_i;
         f_xor_key_end   <= bus.xor_key_end_i;
         f_xor_lsb       <= bus.xor_lsb_i;
      end
   end

   // The first round loads external state unless continuing from the register.
   assign bus.counter_o        = (state == ST_DONE) ? RND_LAST :
                                 in_busy            ? rnd      : 4'd0;
   assign bus.data_sel_o       = in_round | (in_first & ~f_load);
   assign bus.en_reg_state_o   = in_busy;
   assign bus.en_xor_data_o    = in_first & f_xor_data;
   assign bus.en_xor_key_o     = in_first & f_xor_key_begin;
   assign bus.en_xor_key_end_o = in_busy & last_round & f_xor_key_end;
   assign bus.en_xor_lsb_o     = in_busy & last_round & f_xor_lsb;
   assign bus.busy_o           = in_busy;
   assign bus.done_o           = (state == ST_DONE);

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for the ASCON permutation sequencer: checks every output each
// cycle against the expected round schedule.
module tb_ascon_perm_ctrl;

   logic clock_i  = 1'b0;
   logic resetb_i = 1'b0;

   ascon_perm_ctrl_if bus ();

   ascon_perm_ctrl dut (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .bus      (bus)
   );

   always #5 clock_i = ~clock_i;

   int n_tests = 0;
   int n_fail  = 0;

   // {counter, data_sel, en_reg, xor_data, xor_key, xor_key_end, xor_lsb, busy, done}
   logic [11:0] obs;
   assign obs = {bus.counter_o, bus.data_sel_o, bus.en_reg_state_o,
                 bus.en_xor_data_o, bus.en_xor_key_o, bus.en_xor_key_end_o,
                 bus.en_xor_lsb_o, bus.busy_o, bus.done_o};

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %03h expected %03h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] vec(input logic [3:0] cnt, input logic ds, input logic er,
                                       input logic xd, input logic xk, input logic xke,
                                       input logic xl, input logic bsy, input logic dn);
      return {cnt, ds, er, xd, xk, xke, xl, bsy, dn};
   endfunction

   localparam logic [11:0] IDLE_VEC = 12'h000;
   localparam logic [11:0] DONE_VEC = {4'd11, 8'b0000_0001};

   task automatic set_cfg(input logic m, input logic ld, input logic xd,
                          input logic xkb, input logic xke, input logic xl);
      bus.mode_i          = m;
      bus.load_i          = ld;
      bus.xor_data_i      = xd;
      bus.xor_key_begin_i = xkb;
      bus.xor_key_end_i   = xke;
      bus.xor_lsb_i       = xl;
   endtask

   // Start one permutation and check every cycle through DONE and back to IDLE.
   // Config inputs are inverted after the start edge to prove they were latched.
   task automatic run_perm(input string name, input logic m, input logic ld, input logic xd,
                           input logic xkb, input logic xke, input logic xl);
      int         n;
      logic [3:0] first;
      n     = m ? 6 : 12;
      first = m ? 4'd6 : 4'd0;
      @(negedge clock_i);
      set_cfg(m, ld, xd, xkb, xke, xl);
      bus.start_i = 1'b1;
      @(negedge clock_i);
      bus.start_i = 1'b0;
      set_cfg(~m, ~ld, ~xd, ~xkb, ~xke, ~xl);
      for (int c = 1; c <= n; c++) begin
         check($sformatf("%s_c%0d", name, c), obs,
               vec(4'(int'(first) + c - 1), (c == 1) ? ~ld : 1'b1, 1'b1,
                   (c == 1) && xd, (c == 1) && xkb, (c == n) && xke, (c == n) && xl,
                   1'b1, 1'b0));
         @(negedge clock_i);
      end
      check($sformatf("%s_done", name), obs, DONE_VEC);
      @(negedge clock_i);
      check($sformatf("%s_idle", name), obs, IDLE_VEC);
   endtask

   initial begin
      bus.start_i = 1'b0;
      set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (2) @(negedge clock_i);
      check("reset", obs, IDLE_VEC);
      resetb_i = 1'b1;
      @(negedge clock_i);
      check("idle_after_reset", obs, IDLE_VEC);

      run_perm("pa_init",  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run_perm("pb_data",  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_perm("pa_final", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      run_perm("pb_lsb",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // start held high: p^b back to back, single DONE between runs
      @(negedge clock_i);
      set_cfg(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.start_i = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clock_i);
         if (((c - 1) % 7) < 6)
            check($sformatf("b2b_c%0d", c), obs,
                  vec(4'(6 + ((c - 1) % 7)), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
         else
            check($sformatf("b2b_c%0d", c), obs, DONE_VEC);
      end
      bus.start_i = 1'b0;
      @(negedge clock_i);
      check("b2b_idle", obs, IDLE_VEC);

      // asynchronous reset at counter 5 of p^a
      set_cfg(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.start_i = 1'b1;
      @(negedge clock_i);
      bus.start_i = 1'b0;
      repeat (5) @(negedge clock_i);
      check("rst_mid_c5", obs, vec(4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      resetb_i = 1'b0;
      #1;
      check("rst_mid_async", obs, IDLE_VEC);
      @(negedge clock_i);
      resetb_i = 1'b1;
      @(negedge clock_i);
      check("rst_mid_idle", obs, IDLE_VEC);
      run_perm("pa_after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ascon_perm_ctrl.md
# ascon_perm_ctrl

Control sequencer that drives the `permutation_simple` datapath through one ASCON permutation, either p^a (12 rounds) or p^b (6 rounds). It produces the round counter, the state-mux select, the state-register enable and the begin/end XOR enables that a bench otherwise drives by hand. It sits between the top-level ASCON mode FSM (initialization, associated data, plaintext, finalization) and the datapath, and exchanges a start/done handshake with the mode FSM.

## Interface

- No parameters.
- `clock_i`  in  1  system clock, rising edge.
- `resetb_i`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request one permutation; sampled in IDLE or DONE.
- `mode_i`  in  1  0 = p^a (counter 0..11), 1 = p^b (counter 6..11); latched at start.
- `load_i`  in  1  1 = first round takes external `state_i` (data_sel=0), 0 = continue from register (data_sel=1); latched at start.
- `xor_data_i`  in  1  XOR data into state before first round; latched at start.
- `xor_key_begin_i`  in  1  XOR key before first round; latched at start.
- `xor_key_end_i`  in  1  XOR key after last round; latched at start.
- `xor_lsb_i`  in  1  XOR domain-separation bit after last round; latched at start.
- `counter_o`  out  4  round constant index to datapath `counter_i`.
- `data_sel_o`  out  1  datapath state-mux select.
- `en_reg_state_o`  out  1  datapath state-register enable.
- `en_xor_data_o`, `en_xor_key_o`  out  1 each  begin-of-permutation XOR enables.
- `en_xor_key_end_o`, `en_xor_lsb_o`  out  1 each  end-of-permutation XOR enables.
- `busy_o`  out  1  permutation in progress (FIRST or ROUND).
- `done_o`  out  1  one-cycle pulse: result is in datapath state register.

## Operation

- States: IDLE, FIRST, ROUND, DONE. All outputs are Moore-decoded from the state register, the 4-bit round register and the latched configuration flags.
- IDLE: all outputs 0. On `start_i`=1, latch the config flags, load the round register with 0 (mode 0) or 6 (mode 1), and go to FIRST.
- FIRST:
  - `en_reg_state_o`=1, `data_sel_o`=~load, `counter_o`=first index.
  - `en_xor_data_o` and `en_xor_key_o` follow their latched flags; both are asserted only in FIRST.
  - Next state ROUND, round register +1.
- ROUND:
  - `en_reg_state_o`=1, `data_sel_o`=1, `counter_o`=round register.
  - While counter < 11: increment and stay in ROUND.
  - When counter = 11: assert `en_xor_key_end_o` and `en_xor_lsb_o` per their latched flags, then go to DONE.
- DONE: `done_o`=1, `en_reg_state_o`=0, other enables 0, `counter_o` holds 11.
  - `start_i`=1 re-latches config and goes to FIRST (back-to-back permutations).
  - Otherwise go to IDLE and clear the round register to 0.
- `start_i` in FIRST or ROUND is ignored. Config inputs are don't-care outside the start cycle.
- The round register never exceeds 11, so no wrap-around occurs. Values 12..15 are unreachable. If one is forced, treat it as the last round: go to DONE.
- Reset mid-operation (asynchronous): return immediately to IDLE with all outputs 0. The datapath register holds undefined/partial data, and the mode FSM restarts.

## Timing

- Reset values: state IDLE, round register 0, all flags 0, all outputs 0.
- Start sampled at edge E0.
- p^a: FIRST is the cycle after E0, then 11 ROUND cycles. `en_reg_state_o` is high for exactly 12 cycles. `done_o` is high in the 13th cycle after E0.
- p^b: 6 cycles of `en_reg_state_o`. `done_o` is high in the 7th cycle after E0.
- End XORs are asserted in the same cycle as `counter_o`=11, the final datapath register load.
- Back-to-back starts: a start in DONE puts FIRST in the next cycle, for a throughput of one permutation per 13 (p^a) or 7 (p^b) cycles.
- No combinational path from any input to any output.

## Test plan

- Reset, then p^a init (load=1, key_end=1, state_i=80400C0600000000/0001020304050607/08090a0b0c0d0e0f/0011223344556677/8899aabbccddeeff, key 000102…0F):
  - Controller behaviour: `counter_o` steps 0..11, `data_sel_o`=0 only at counter 0, `en_xor_key_end_o`=1 only at counter 11, `done_o` pulse 13 cycles after start.
  - Datapath result: `state_o` matches the hand-driven `permutation_simple` sequence.
- p^b with xor_data=1, load=0:
  - `counter_o` steps 6..11.
  - `en_xor_data_o`=1 only at counter 6.
  - `data_sel_o`=1 throughout.
  - `done_o` 7 cycles after start.
- Finalization p^a with xor_key_begin=1, xor_key_end=1, xor_lsb=0:
  - `en_xor_key_o` at counter 0 only.
  - `en_xor_key_end_o` at counter 11 only.
  - `en_xor_lsb_o` never asserted.
- `start_i` held high continuously:
  - permutations run back-to-back with a single DONE cycle between them.
  - a start pulse during ROUND does not disturb `counter_o`.
- `resetb_i` low at counter 5 of p^a: all outputs 0 immediately. After release the block is idle and a new start yields a full 0..11 sequence.
